imm_ext_pipe: RTL and testbench

Parametrised, registered successor to the combinational immediate extender. It takes the 25-bit instruction payload (instr[31:7]) and an immediate-source code, and produces an XLEN-wide immediate, a pass-through tag and an illegal flag. The result is held in a 2-entry skid buffer with valid/ready handshakes on both sides, so the block sits as a decode-stage pipeline slice that tolerates execute-side backpressure. XLEN=64 and the CSR-zimm and shift-amount forms are new.

---
 rtl/imm_ext_pkg.sv | 23 ++
 rtl/imm_ext_core.sv | 69 ++++++
 rtl/imm_ext_pipe.sv | 115 +++++++++++
 tb/tb_imm_ext_pipe.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared immediate-source codes and XLEN legality check for the
// immediate extender slice.
package imm_ext_pkg;

   // Existing codes keep their values; IMM_Z and IMM_SH are appended.
   typedef enum logic [2:0] {
      IMM_I  = 3'd0,
      IMM_S  = 3'd1,
      IMM_B  = 3'd2,
      IMM_J  = 3'd3,
      IMM_U  = 3'd4,
      IMM_Z  = 3'd5,
      IMM_SH = 3'd6
   } imm_src_e;

   localparam int XLEN_RV32 = 32;
   localparam int XLEN_RV64 = 64;

   function automatic bit xlen_ok(int x);
      return (x == XLEN_RV32) || (x == XLEN_RV64);
   endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Combinational decode/extend of instr[31:7] into an XLEN immediate.
// Ports: imm_i (instr[31:7]), imm_src_i (code), imm_o, illegal_o.
module imm_ext_core
   import imm_ext_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [24:0]     imm_i,
   input  logic [2:0]      imm_src_i,
   output logic [XLEN-1:0] imm_o,
   output logic            illegal_o
);

   if (!xlen_ok(XLEN)) begin : g_bad_xlen
      $error("imm_ext_core: XLEN must be 32 or 64");
   end

   logic [31:0] v;
   logic        sx;

   always_comb begin
      v         = '0;
      sx        = 1'b0;
      illegal_o = 1'b0;
      unique case (imm_src_i)
         IMM_I: begin
            v  = {{20{imm_i[24]}}, imm_i[24:13]};
            sx = 1'b1;
         end
         IMM_S: begin
            v  = {{20{imm_i[24]}}, imm_i[24:18], imm_i[4:0]};
            sx = 1'b1;
         end
         IMM_B: begin
            v  = {{20{imm_i[24]}}, imm_i[0], imm_i[23:18],
                  imm_i[4:1], 1'b0};
            sx = 1'b1;
         end
         IMM_J: begin
            v  = {{12{imm_i[24]}}, imm_i[12:5], imm_i[13],
                  imm_i[23:14], 1'b0};
            sx = 1'b1;
         end
         IMM_U: begin
            v  = {imm_i[24:5], 12'b0};
            sx = 1'b1;
         end
         IMM_Z: begin
            v = {27'b0, imm_i[12:8]};
         end
         IMM_SH: begin
            // RV32 has 5-bit shamt; shamt[5] set is reserved there.
            if (XLEN == XLEN_RV32) begin
               if (imm_i[18]) illegal_o = 1'b1;
               else           v = {27'b0, imm_i[17:13]};
            end else begin
               v = {26'b0, imm_i[18:13]};
            end
         end
         default: begin
            illegal_o = 1'b1;
         end
      endcase
      // Signed forms are already 32-bit extended; widen from bit 31.
      if (sx) imm_o = XLEN'($signed(v));
      else    imm_o = XLEN'(v);
   end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender with a 2-entry skid buffer (M out, K skid).
// Ports: clk, rst_n, flush, in_valid/in_ready, imm, imm_src, in_tag,
// out_valid/out_ready, imm_ext, out_tag, out_illegal.
module imm_ext_pipe
   import imm_ext_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [24:0]      imm,
   input  logic [2:0]       imm_src,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  imm_ext,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal
);

   logic [XLEN-1:0]  c_imm;
   logic             c_ill;

   imm_ext_core #(.XLEN(XLEN)) u_core (
      .imm_i     (imm),
      .imm_src_i (imm_src),
      .imm_o     (c_imm),
      .illegal_o (c_ill)
   );

   logic             m_vld_q, m_vld_d;
   logic [XLEN-1:0]  m_imm_q, m_imm_d;
   logic [TAG_W-1:0] m_tag_q, m_tag_d;
   logic             m_ill_q, m_ill_d;
   logic             k_vld_q, k_vld_d;
   logic [XLEN-1:0]  k_imm_q, k_imm_d;
   logic [TAG_W-1:0] k_tag_q, k_tag_d;
   logic             k_ill_q, k_ill_d;

   logic in_fire;
   logic out_fire;

   assign in_ready    = ~k_vld_q;
   assign out_valid   = m_vld_q;
   assign imm_ext     = m_imm_q;
   assign out_tag     = m_tag_q;
   assign out_illegal = m_ill_q;

   assign in_fire  = in_valid & ~k_vld_q;
   assign out_fire = m_vld_q & out_ready;

   always_comb begin
      m_vld_d = m_vld_q;
      m_imm_d = m_imm_q;
      m_tag_d = m_tag_q;
      m_ill_d = m_ill_q;
      k_vld_d = k_vld_q;
      k_imm_d = k_imm_q;
      k_tag_d = k_tag_q;
      k_ill_d = k_ill_q;
      if (flush) begin
         m_vld_d = 1'b0;
         k_vld_d = 1'b0;
      end else if (k_vld_q) begin
         // Input is blocked while K holds an entry.
         if (out_fire) begin
            m_imm_d = k_imm_q;
            m_tag_d = k_tag_q;
            m_ill_d = k_ill_q;
            k_vld_d = 1'b0;
         end
      end else if (in_fire) begin
         if (!m_vld_q || out_fire) begin
            m_vld_d = 1'b1;
            m_imm_d = c_imm;
            m_tag_d = in_tag;
            m_ill_d = c_ill;
         end else begin
            k_vld_d = 1'b1;
            k_imm_d = c_imm;
            k_tag_d = in_tag;
            k_ill_d = c_ill;
         end
      end else if (out_fire) begin
         m_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_vld_q <= 1'b0;
         m_imm_q <= '0;
         m_tag_q <= '0;
         m_ill_q <= 1'b0;
         k_vld_q <= 1'b0;
         k_imm_q <= '0;
         k_tag_q <= '0;
         k_ill_q <= 1'b0;
      end else begin
         m_vld_q <= m_vld_d;
         m_imm_q <= m_imm_d;
         m_tag_q <= m_tag_d;
         m_ill_q <= m_ill_d;
         k_vld_q <= k_vld_d;
         k_imm_q <= k_imm_d;
         k_tag_q <= k_tag_d;
         k_ill_q <= k_ill_d;
      end
   end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Randomised bench for imm_ext_pipe at XLEN=32 and XLEN=64 side by side,
// checked against a queue-based behavioural model.
module tb_imm_ext_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [24:0] imm;
   logic [2:0]  imm_src;
   logic [31:0] in_tag;

   logic        rdy32, vld32, ill32;
   logic [31:0] ext32, tag32;
   logic        rdy64, vld64, ill64;
   logic [63:0] ext64;
   logic [31:0] tag64;

   always #5 clk = ~clk;

   imm_ext_pipe #(.XLEN(32), .TAG_W(32)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy32),
      .imm(imm), .imm_src(imm_src), .in_tag(in_tag),
      .out_valid(vld32), .out_ready(out_ready),
      .imm_ext(ext32), .out_tag(tag32), .out_illegal(ill32)
   );

   imm_ext_pipe #(.XLEN(64), .TAG_W(32)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy64),
      .imm(imm), .imm_src(imm_src), .in_tag(in_tag),
      .out_valid(vld64), .out_ready(out_ready),
      .imm_ext(ext64), .out_tag(tag64), .out_illegal(ill64)
   );

   typedef struct {
      logic [24:0] imm;
      logic [2:0]  src;
      logic [31:0] tag;
   } ent_t;

   ent_t q[$];
   int   nchk = 0;
   int   nerr = 0;
   int   nout = 0;
   bit   last_in_fire = 0;

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic longint sext(longint x, int n);
      if (x >= (longint'(1) << (n - 1))) return x - (longint'(1) << n);
      return x;
   endfunction

   // Immediate value from the ISA field definitions, as plain arithmetic.
   function automatic logic [64:0] ref_out(int xlen, logic [24:0] im,
                                           logic [2:0] src);
      longint v;
      bit     ill;
      v   = 0;
      ill = 0;
      case (src)
         3'd0: v = sext(longint'(im[24:13]), 12);
         3'd1: v = sext(longint'(im[24:18]) * 32 + longint'(im[4:0]), 12);
         3'd2: v = sext(longint'(im[24]) * 4096 + longint'(im[0]) * 2048
                        + longint'(im[23:18]) * 32
                        + longint'(im[4:1]) * 2, 13);
         3'd3: v = sext(longint'(im[24]) * 1048576
                        + longint'(im[12:5]) * 4096
                        + longint'(im[13]) * 2048
                        + longint'(im[23:14]) * 2, 21);
         3'd4: v = sext(longint'(im[24:5]) * 4096, 32);
         3'd5: v = longint'(im[12:8]);
         3'd6: begin
            if (xlen == 32) begin
               if (im[18]) ill = 1;
               else        v = longint'(im[17:13]);
            end else begin
               v = longint'(im[18:13]);
            end
         end
         default: ill = 1;
      endcase
      if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
      return {ill, v[63:0]};
   endfunction

   task automatic check_outputs();
      logic [64:0] r;
      chk("rdy32", {63'b0, rdy32}, {63'b0, q.size() < 2});
      chk("vld32", {63'b0, vld32}, {63'b0, q.size() > 0});
      chk("rdy64", {63'b0, rdy64}, {63'b0, q.size() < 2});
      chk("vld64", {63'b0, vld64}, {63'b0, q.size() > 0});
      if (q.size() > 0) begin
         r = ref_out(32, q[0].imm, q[0].src);
         chk("imm32", {32'b0, ext32}, r[63:0]);
         chk("ill32", {63'b0, ill32}, {63'b0, r[64]});
         chk("tag32", {32'b0, tag32}, {32'b0, q[0].tag});
         r = ref_out(64, q[0].imm, q[0].src);
         chk("imm64", ext64, r[63:0]);
         chk("ill64", {63'b0, ill64}, {63'b0, r[64]});
         chk("tag64", {32'b0, tag64}, {32'b0, q[0].tag});
      end
   endtask

   // Called just after a negedge with inputs driven; returns at next negedge.
   task automatic cycle();
      bit   in_f, out_f;
      ent_t e;
      check_outputs();
      in_f  = in_valid && (q.size() < 2) && !flush;
      out_f = (q.size() > 0) && out_ready && !flush;
      e.imm = imm;
      e.src = imm_src;
      e.tag = in_tag;
      @(posedge clk);
      if (flush) begin
         q.delete();
      end else begin
         if (out_f) begin
            void'(q.pop_front());
            nout++;
         end
         if (in_f) q.push_back(e);
      end
      last_in_fire = in_f;
      @(negedge clk);
   endtask

   task automatic drive(logic [24:0] i, logic [2:0] s, logic [31:0] t);
      in_valid = 1'b1;
      imm      = i;
      imm_src  = s;
      in_tag   = t;
   endtask

   task automatic chk_reset_outputs(string tag);
      chk({tag, "_vld32"}, {63'b0, vld32}, 64'd0);
      chk({tag, "_rdy32"}, {63'b0, rdy32}, 64'd1);
      chk({tag, "_imm32"}, {32'b0, ext32}, 64'd0);
      chk({tag, "_tag32"}, {32'b0, tag32}, 64'd0);
      chk({tag, "_ill32"}, {63'b0, ill32}, 64'd0);
      chk({tag, "_vld64"}, {63'b0, vld64}, 64'd0);
      chk({tag, "_rdy64"}, {63'b0, rdy64}, 64'd1);
      chk({tag, "_imm64"}, ext64, 64'd0);
      chk({tag, "_ill64"}, {63'b0, ill64}, 64'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      imm       = '0;
      imm_src   = '0;
      in_tag    = '0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("rst");
      rst_n = 1'b1;
      cycle();

      // I-type all ones, 1-cycle latency
      out_ready = 1'b1;
      drive(25'h1FFE000, 3'd0, 32'h100);
      cycle();
      in_valid = 1'b0;
      chk("tp1_vld", {63'b0, vld32}, 64'd1);
      chk("tp1_imm", {32'b0, ext32}, 64'hFFFF_FFFF);
      chk("tp1_tag", {32'b0, tag32}, 64'h100);
      chk("tp1_ill", {63'b0, ill32}, 64'd0);
      cycle();

      // U sign-extension and Z at XLEN=64
      drive(25'h1000000, 3'd4, 32'h200);
      cycle();
      in_valid = 1'b0;
      chk("tpU_imm64", ext64, 64'hFFFF_FFFF_8000_0000);
      chk("tpU_imm32", {32'b0, ext32}, 64'h8000_0000);
      cycle();
      drive(25'h1001F00, 3'd5, 32'h201);
      cycle();
      in_valid = 1'b0;
      chk("tpZ_imm64", ext64, 64'h1F);
      cycle();

      // Shift amount with bit 5 set, and the undefined code
      drive(25'h0040000, 3'd6, 32'h300);
      cycle();
      in_valid = 1'b0;
      chk("tpSH_ill32", {63'b0, ill32}, 64'd1);
      chk("tpSH_imm32", {32'b0, ext32}, 64'd0);
      chk("tpSH_ill64", {63'b0, ill64}, 64'd0);
      chk("tpSH_imm64", ext64, 64'h20);
      cycle();
      drive(25'h1FFFFFF, 3'd7, 32'h301);
      cycle();
      in_valid = 1'b0;
      chk("tp7_ill32", {63'b0, ill32}, 64'd1);
      chk("tp7_imm32", {32'b0, ext32}, 64'd0);
      chk("tp7_imm64", ext64, 64'd0);
      cycle();

      // A,B,C under backpressure, then drain in order
      out_ready = 1'b0;
      nout = 0;
      drive(25'h0123456, 3'd1, 32'hA);
      cycle();
      drive(25'h1ABCDEF, 3'd2, 32'hB);
      cycle();
      drive(25'h0F0F0F0, 3'd3, 32'hC);
      chk("abc_rdy32", {63'b0, rdy32}, 64'd0);
      chk("abc_tagA", {32'b0, tag32}, 64'hA);
      cycle();
      cycle();
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cycle();
         if (last_in_fire) in_valid = 1'b0;
      end
      chk("abc_count", 64'(nout), 64'd3);

      // Full throughput
      nout = 0;
      for (int i = 0; i < 8; i++) begin
         drive(25'($urandom), 3'($urandom_range(0, 6)), 32'(i));
         cycle();
      end
      in_valid = 1'b0;
      cycle();
      chk("tput_count", 64'(nout), 64'd8);

      // Flush with M and K full, input offered in same cycle
      out_ready = 1'b0;
      drive(25'h1FFE000, 3'd0, 32'h51);
      cycle();
      drive(25'h1FFE000, 3'd1, 32'h52);
      cycle();
      drive(25'h0000001, 3'd0, 32'h53);
      flush = 1'b1;
      cycle();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_vld", {63'b0, vld32}, 64'd0);
      chk("flush_rdy", {63'b0, rdy32}, 64'd1);
      cycle();

      // Asynchronous reset mid-stall
      drive(25'h1FFE000, 3'd0, 32'h61);
      cycle();
      drive(25'h1FFE000, 3'd4, 32'h62);
      cycle();
      in_valid = 1'b0;
      cycle();
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("arst");
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      cycle();

      // Random traffic with occasional flush
      in_valid = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!in_valid || last_in_fire) begin
            in_valid = ($urandom_range(0, 3) != 0);
            imm      = 25'($urandom);
            imm_src  = 3'($urandom_range(0, 7));
            in_tag   = $urandom;
         end
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         cycle();
      end
      flush    = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (3) cycle();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
